// File: rtl/led_sw_mode_ctrl.sv
// Switch synchroniser and debouncer feeding per-LED mode logic: off, follow,
// toggle-on-press, or blink-while-on. All outputs are registered.
module led_sw_mode_ctrl #(
  parameter int unsigned LED_NUM    = 4,
  parameter int unsigned SW_NUM     = 3,
  parameter int unsigned DEB_CYCLES = 1_000_000,
  parameter int unsigned BLINK_HALF = 25_000_000
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic [SW_NUM-1:0]    sw,
  input  logic [2*LED_NUM-1:0] mode,
  output logic [LED_NUM-1:0]   led,
  output logic [SW_NUM-1:0]    sw_db,
  output logic [SW_NUM-1:0]    sw_rise
);

  localparam int unsigned DW = $clog2(DEB_CYCLES + 1);
  localparam int unsigned BW = $clog2(BLINK_HALF);
  localparam logic [DW-1:0] DEB_LAST   = DW'(DEB_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

  typedef enum logic [1:0] {
    MODE_OFF    = 2'b00,
    MODE_FOLLOW = 2'b01,
    MODE_TOGGLE = 2'b10,
    MODE_BLINK  = 2'b11
  } led_mode_e;

  logic [SW_NUM-1:0] meta_q;
  logic [SW_NUM-1:0] sync_q;
  logic [SW_NUM-1:0] db_q;
  logic [SW_NUM-1:0] db_dly_q;
  logic [SW_NUM-1:0] rise_d;
  logic [SW_NUM-1:0] rise_q;
  logic [BW-1:0]     blink_cnt_q;
  logic [BW-1:0]     blink_cnt_d;
  logic              phase_q;
  logic              phase_d;

  always_comb begin
    rise_d = db_q & ~db_dly_q;
  end

  always_comb begin
    blink_cnt_d = blink_cnt_q + 1'b1;
    phase_d     = phase_q;
    if (blink_cnt_q == BLINK_LAST) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta_q      <= '0;
      sync_q      <= '0;
      db_dly_q    <= '0;
      rise_q      <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      meta_q      <= sw;
      sync_q      <= meta_q;
      db_dly_q    <= db_q;
      rise_q      <= rise_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
    end
  end

  // One debouncer per switch; a disagreement must persist DEB_CYCLES samples.
  for (genvar gj = 0; gj < SW_NUM; gj++) begin : g_deb
    logic [DW-1:0] cnt_q;
    logic [DW-1:0] cnt_d;
    logic          db_bit_q;
    logic          db_bit_d;

    always_comb begin
      cnt_d    = '0;
      db_bit_d = db_bit_q;
      if (sync_q[gj] != db_bit_q) begin
        if (cnt_q == DEB_LAST) begin
          db_bit_d = sync_q[gj];
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        cnt_q    <= '0;
        db_bit_q <= 1'b0;
      end else begin
        cnt_q    <= cnt_d;
        db_bit_q <= db_bit_d;
      end
    end

    assign db_q[gj] = db_bit_q;
  end

  for (genvar gi = 0; gi < LED_NUM; gi++) begin : g_led
    localparam int unsigned SJ = gi % SW_NUM;
    led_mode_e mode_sel;
    logic      tog_q;
    logic      tog_d;
    logic      led_q;
    logic      led_d;

    assign mode_sel = led_mode_e'(mode[2*gi +: 2]);

    // Toggle flips on the combinational rise term, so led sees it one edge later.
    always_comb begin
      tog_d = tog_q;
      led_d = 1'b0;
      case (mode_sel)
        MODE_OFF: begin
          tog_d = 1'b0;
        end
        MODE_FOLLOW: begin
          led_d = db_q[SJ];
        end
        MODE_TOGGLE: begin
          led_d = tog_q;
          if (rise_d[SJ]) begin
            tog_d = ~tog_q;
          end
        end
        MODE_BLINK: begin
          led_d = db_q[SJ] & phase_q;
        end
      endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        tog_q <= 1'b0;
        led_q <= 1'b0;
      end else begin
        tog_q <= tog_d;
        led_q <= led_d;
      end
    end

    assign led[gi] = led_q;
  end

  assign sw_db   = db_q;
  assign sw_rise = rise_q;

endmodule

// File: tb/tb_led_sw_mode_ctrl.sv
// Randomised bench for led_sw_mode_ctrl against a sample-history reference model.
module tb_led_sw_mode_ctrl;

  localparam int LED_NUM = 4;
  localparam int SW_NUM  = 3;
  localparam int DEB     = 4;
  localparam int BH      = 5;

  logic       clk = 1'b0;
  logic       resetn;
  logic [2:0] sw;
  logic [7:0] mode;
  logic [3:0] led;
  logic [2:0] sw_db;
  logic [2:0] sw_rise;

  int checks = 0;
  int errors = 0;

  // Model: h_raw[n] = sw seen by edge n, h_db[n] = debounced level after edge n.
  logic [2:0] h_raw[$];
  logic [2:0] h_db[$];
  int         n;
  logic [3:0] m_led;
  logic [3:0] m_tog;
  logic [2:0] m_db;
  logic [2:0] m_rise;

  led_sw_mode_ctrl #(
    .LED_NUM   (LED_NUM),
    .SW_NUM    (SW_NUM),
    .DEB_CYCLES(DEB),
    .BLINK_HALF(BH)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .sw     (sw),
    .mode   (mode),
    .led    (led),
    .sw_db  (sw_db),
    .sw_rise(sw_rise)
  );

  always #5 clk = ~clk;

  function automatic logic [2:0] sync_at(int m);
    return (m >= 1) ? h_raw[m-1] : 3'b000;
  endfunction

  function automatic logic [2:0] db_at(int m);
    return (m >= 0) ? h_db[m] : 3'b000;
  endfunction

  task automatic model_reset();
    n = 0;
    h_raw.delete();
    h_db.delete();
    h_raw.push_back(3'b000);
    h_db.push_back(3'b000);
    m_led  = '0;
    m_tog  = '0;
    m_db   = '0;
    m_rise = '0;
  endtask

  task automatic step();
    logic [2:0] s, dprev, nd, rise_t, sm;
    logic [7:0] md;
    logic       r, flip, ph_prev;
    logic [3:0] nt, nl;
    logic [1:0] ii, jj, mi;
    s  = sw;
    md = mode;
    r  = resetn;
    @(posedge clk);
    #1;
    if (!r) begin
      model_reset();
    end else begin
      n++;
      h_raw.push_back(s);
      dprev = h_db[n-1];
      nd    = dprev;
      for (int j = 0; j < SW_NUM; j++) begin
        jj = 2'(j);
        if (n >= DEB) begin
          flip = 1'b1;
          for (int m = n - DEB; m < n; m++) begin
            sm = sync_at(m);
            if (sm[jj] == dprev[jj] || h_db[m][jj] != dprev[jj]) flip = 1'b0;
          end
          if (flip) nd[jj] = ~dprev[jj];
        end
      end
      h_db.push_back(nd);
      rise_t  = dprev & ~db_at(n - 2);
      ph_prev = (((n - 1) / BH) % 2) == 1;
      nt = m_tog;
      nl = '0;
      for (int i = 0; i < LED_NUM; i++) begin
        ii = 2'(i);
        jj = 2'(i % SW_NUM);
        mi = md[{ii, 1'b0} +: 2];
        case (mi)
          2'b00: nt[ii] = 1'b0;
          2'b01: nl[ii] = dprev[jj];
          2'b10: begin
            nl[ii] = m_tog[ii];
            if (rise_t[jj]) nt[ii] = ~m_tog[ii];
          end
          default: nl[ii] = dprev[jj] & ph_prev;
        endcase
      end
      m_tog  = nt;
      m_led  = nl;
      m_db   = nd;
      m_rise = rise_t;
    end
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    sw     = '0;
    mode   = '0;
    model_reset();
    repeat (2) step();
    checks++;
    if ({led, sw_db, sw_rise} !== 10'b0) begin
      errors++;
      $display("FAIL reset_init got=%b exp=0", {led, sw_db, sw_rise});
    end
    resetn = 1'b1;
    mode   = 8'h55;
    sw     = 3'b111;
    repeat (8) begin
      step();
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
        errors++;
        $display("FAIL reset_warm got=%b exp=%b", {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
    end
    #3 resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({led, sw_db, sw_rise} !== 10'b0) begin
      errors++;
      $display("FAIL reset_async got=%b exp=0", {led, sw_db, sw_rise});
    end
    #2 resetn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
        errors++;
        $display("FAIL reset_release e=%0d got=%b exp=%b", e, {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
      if (e == 5) begin
        checks++;
        if (sw_db !== 3'b000) begin
          errors++;
          $display("FAIL reset_db_early e=%0d got=%b exp=000", e, sw_db);
        end
      end
      if (e == 6) begin
        checks++;
        if (sw_db !== 3'b111) begin
          errors++;
          $display("FAIL reset_db_latency e=%0d got=%b exp=111", e, sw_db);
        end
      end
    end
  endtask

  task automatic test_direct_alias();
    int rises;
    mode = 8'h55;
    sw   = 3'b000;
    repeat (8) begin
      step();
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
        errors++;
        $display("FAIL direct_settle got=%b exp=%b", {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
    end
    sw[0] = 1'b1;
    rises = 0;
    for (int e = 1; e <= 9; e++) begin
      step();
      if (sw_rise[0]) rises++;
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
        errors++;
        $display("FAIL direct_model e=%0d got=%b exp=%b", e, {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
      if (e == 6) begin
        checks++;
        if (led[0] !== 1'b0) begin
          errors++;
          $display("FAIL direct_led0_early got=%b exp=0", led[0]);
        end
      end
      if (e == 7) begin
        checks++;
        if ({led[3], led[0], sw_rise[0]} !== 3'b111) begin
          errors++;
          $display("FAIL direct_alias_rise got=%b exp=111", {led[3], led[0], sw_rise[0]});
        end
      end
      if (e == 8) begin
        checks++;
        if (sw_rise[0] !== 1'b0) begin
          errors++;
          $display("FAIL direct_rise_width got=%b exp=0", sw_rise[0]);
        end
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL direct_rise_count got=%0d exp=1", rises);
    end
  endtask

  task automatic test_bounce();
    int rises;
    mode[7:6] = 2'($urandom);
    for (int p = 0; p < 4; p++) begin
      sw[1] = (p % 2) == 0;
      repeat (3) begin
        step();
        checks++;
        if ({sw_db[1], sw_rise[1]} !== 2'b00 || {led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
          errors++;
          $display("FAIL bounce_glitch got=%b exp=%b", {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
        end
      end
    end
    sw[1] = 1'b1;
    rises = 0;
    for (int e = 1; e <= 10; e++) begin
      step();
      if (sw_rise[1]) rises++;
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
        errors++;
        $display("FAIL bounce_model e=%0d got=%b exp=%b", e, {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
      if (e == 5 || e == 6) begin
        checks++;
        if (sw_db[1] !== (e == 6)) begin
          errors++;
          $display("FAIL bounce_db e=%0d got=%b exp=%b", e, sw_db[1], e == 6);
        end
      end
      if (e == 7) begin
        checks++;
        if (sw_rise[1] !== 1'b1) begin
          errors++;
          $display("FAIL bounce_rise_time got=%b exp=1", sw_rise[1]);
        end
      end
    end
    checks++;
    if (rises != 1) begin
      errors++;
      $display("FAIL bounce_rise_count got=%0d exp=1", rises);
    end
  endtask

  task automatic test_toggle();
    sw[1]     = 1'b0;
    mode[3:2] = 2'b00;
    mode[7:4] = 4'($urandom);
    repeat (8) begin
      step();
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
        errors++;
        $display("FAIL toggle_settle got=%b exp=%b", {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
    end
    mode[3:2] = 2'b10;
    for (int p = 0; p < 3; p++) begin
      for (int h = 0; h < 20; h++) begin
        sw[1] = h < 10;
        step();
        checks++;
        if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
          errors++;
          $display("FAIL toggle_model p=%0d h=%0d got=%b exp=%b", p, h, {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
        end
        if (h == 9) begin
          checks++;
          if (led[1] !== ((p % 2) == 0)) begin
            errors++;
            $display("FAIL toggle_press p=%0d got=%b exp=%b", p, led[1], (p % 2) == 0);
          end
        end
      end
    end
    mode[3:2] = 2'b00;
    step();
    checks++;
    if (led[1] !== 1'b0) begin
      errors++;
      $display("FAIL toggle_off got=%b exp=0", led[1]);
    end
    mode[3:2] = 2'b10;
    step();
    checks++;
    if (led[1] !== 1'b0 || {led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
      errors++;
      $display("FAIL toggle_cleared got=%b exp=%b", {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
    end
  endtask

  task automatic test_blink();
    int   last;
    int   changes;
    logic prev;
    mode[5:4] = 2'b11;
    sw[2]     = 1'b1;
    repeat (8) begin
      step();
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
        errors++;
        $display("FAIL blink_settle got=%b exp=%b", {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
    end
    last    = -1;
    changes = 0;
    prev    = led[2];
    for (int e = 1; e <= 20; e++) begin
      step();
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
        errors++;
        $display("FAIL blink_model e=%0d got=%b exp=%b", e, {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
      if (led[2] !== prev) begin
        if (last >= 0) begin
          checks++;
          if (e - last != BH) begin
            errors++;
            $display("FAIL blink_interval got=%0d exp=%0d", e - last, BH);
          end
        end
        last = e;
        changes++;
        prev = led[2];
      end
    end
    checks++;
    if (changes < 3) begin
      errors++;
      $display("FAIL blink_activity got=%0d exp>=3", changes);
    end
    sw[2] = 1'b0;
    for (int e = 1; e <= 19; e++) begin
      step();
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise} || (e > 7 && led[2] !== 1'b0)) begin
        errors++;
        $display("FAIL blink_release e=%0d got=%b exp=%b", e, {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
    end
  endtask

  task automatic test_reset_middeb();
    mode = 8'h55;
    sw   = 3'b000;
    repeat (8) step();
    sw[0] = 1'b1;
    repeat (4) step();
    #3 resetn = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({led, sw_db, sw_rise} !== 10'b0) begin
      errors++;
      $display("FAIL middeb_async got=%b exp=0", {led, sw_db, sw_rise});
    end
    #2 resetn = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
        errors++;
        $display("FAIL middeb_model e=%0d got=%b exp=%b", e, {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
      if (e >= 5 && e <= 7) begin
        checks++;
        if ({sw_db[0], led[0]} !== {e >= 6, e >= 7}) begin
          errors++;
          $display("FAIL middeb_latency e=%0d got=%b exp=%b", e, {sw_db[0], led[0]}, {e >= 6, e >= 7});
        end
      end
    end
  endtask

  task automatic test_random();
    int left;
    left = 0;
    for (int c = 0; c < 400; c++) begin
      if (left == 0) begin
        sw   = 3'($urandom);
        left = $urandom_range(1, 8);
        if ($urandom_range(0, 3) == 0) mode = 8'($urandom);
      end
      left--;
      step();
      checks++;
      if ({led, sw_db, sw_rise} !== {m_led, m_db, m_rise}) begin
        errors++;
        $display("FAIL random c=%0d got=%b exp=%b", c, {led, sw_db, sw_rise}, {m_led, m_db, m_rise});
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct_alias();
    test_bounce();
    test_toggle();
    test_blink();
    test_reset_middeb();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/led_sw_mode_ctrl.md
# led_sw_mode_ctrl

Second-generation switch-to-LED controller for the board I/O path. It synchronises and debounces `SW_NUM` raw slide/push switches and drives `LED_NUM` LEDs. Each LED has its own 2-bit mode: off, direct follow, toggle-on-press, or blink-while-on. It sits between the board switch pins and the LED pins. Other logic may take the cleaned-up `sw_db` and `sw_rise` outputs.

## Interface
- `LED_NUM`, 4: number of LED outputs, ≥1.
- `SW_NUM`, 3: number of switch inputs, ≥1. LED i is served by switch j = i mod `SW_NUM`.
- `DEB_CYCLES`, 1_000_000: consecutive stable cycles required to accept a switch change, ≥1. This is 10 ms at 100 MHz.
- `BLINK_HALF`, 25_000_000: blink half-period in cycles, ≥2.
- `clk` input 1: single system clock.
- `resetn` input 1: asynchronous, active-low reset. All flops clear immediately on assertion.
- `sw` input `SW_NUM`: raw asynchronous switch pins.
- `mode` input 2*`LED_NUM`: `mode[2i+1:2i]` selects the mode of LED i. Synchronous to `clk`.
- `led` output `LED_NUM`: registered LED drive.
- `sw_db` output `SW_NUM`: registered debounced switch level.
- `sw_rise` output `SW_NUM`: registered one-cycle pulse on each debounced 0→1 transition.

## Operation
- **Synchroniser:** each `sw[j]` passes through a 2-flop chain giving `sw_sync[j]`. Reset value is 0.
- **Debouncer**, one per switch:
  - Counter width is clog2(`DEB_CYCLES`+1).
  - If `sw_sync` == `sw_db`, the counter clears.
  - Otherwise the counter increments.
  - When the counter is at `DEB_CYCLES`-1 and `sw_sync` still differs, `sw_db` <= `sw_sync` and the counter clears.
  - A glitch shorter than `DEB_CYCLES` cycles never reaches `sw_db`.
  - Rising and falling transitions are debounced identically.
- **Edge detect:** `sw_db_q` <= `sw_db` every cycle. The rise term is `sw_db & ~sw_db_q`, and `sw_rise` <= rise term.
- **Toggle state** `tog[i]`:
  - Flips on the rise term of switch j while `mode[i]` == 10.
  - Cleared while `mode[i]` == 00.
  - Held unchanged in modes 01 and 11.
- **Blink timer:**
  - One shared free-running counter over 0..`BLINK_HALF`-1.
  - `phase` toggles on each wrap.
  - The counter is never reset by mode or switch activity.
- **LED register,** per LED every cycle:
  - 00 → `led[i]` <= 0.
  - 01 → `led[i]` <= `sw_db[j]`.
  - 10 → `led[i]` <= `tog[i]`.
  - 11 → `led[i]` <= `sw_db[j]` & `phase`.
- **Mode changes** take effect on the next `led` update. No output glitch beyond one cycle of the old mode.

## Timing
- **Reset values:** `led` = 0, `sw_db` = 0, `sw_rise` = 0. Internally, `tog`, `phase`, all counters and the synchroniser flops are also 0.
- **Direct-mode latency.** Let `sw[j]` change and hold stable before clock edge k:
  - `sw_sync` changes at edge k+1.
  - `sw_db` changes at edge k+1+`DEB_CYCLES`.
  - `led` (mode 01) and `sw_rise` change at edge k+2+`DEB_CYCLES`.
  - `sw_rise` falls at edge k+3+`DEB_CYCLES`.
- **Toggle mode:** `tog` flips at edge k+2+`DEB_CYCLES`, and `led` reflects it at edge k+3+`DEB_CYCLES`.
- **Blink:** after reset release, `phase` first goes to 1 at the `BLINK_HALF`-th clock edge. The period is 2·`BLINK_HALF` cycles with 50% duty.
- **Bounce:** an input that returns to the `sw_db` value before the counter hits `DEB_CYCLES`-1 clears the counter. A fresh full count is then needed.
- **Aliased LEDs:** several LEDs mapped to the same switch all see the same rise pulse on the same cycle.
- **Unmapped switches:** switches with index ≥ `LED_NUM` are still debounced and reported on `sw_db`/`sw_rise`.
- **Reset mid-debounce or mid-blink:** everything returns to the reset values. After release, a held-high switch needs the full 2+`DEB_CYCLES` cycles to register.

## Test plan
Bench parameters: `LED_NUM`=4, `SW_NUM`=3, `DEB_CYCLES`=4, `BLINK_HALF`=5.

- **Reset values:** assert `resetn`=0 mid-cycle with `sw`=111 → all outputs 0 immediately. Release with `sw` held 111 → `sw_db`=111 exactly 5 edges after the first sampling edge.
- **Direct mode and aliasing:** `mode`=01 on all LEDs, `sw[0]` 0→1 stable →
  - `led[0]`=1 and `led[3]`=1 (alias of switch 0) six edges after the change.
  - `sw_rise[0]` high for exactly 1 cycle.
- **Bounce rejection:** `sw[1]` toggles 1,0,1,0 with 3-cycle pulses, then holds 1 →
  - No `sw_db`/`sw_rise` activity during the bouncing.
  - A single `sw_rise[1]` pulse 6 edges after the final hold begins.
- **Toggle mode:** `mode[1]`=10. Three clean presses of `sw[1]` (each held ≥10 cycles, released ≥10 cycles) → `led[1]` sequence 1,0,1. Switching to mode 00 → `led[1]`=0 next cycle and `tog[1]` cleared.
- **Blink mode:** `mode[2]`=11 with `sw[2]` debounced high → `led[2]` toggles every 5 cycles. Releasing `sw[2]` → `led[2]`=0 held after the debounce latency, regardless of `phase`.
- **Reset mid-debounce:** `sw[0]` high for 2 cycles after `sw_sync` changes, then `resetn` pulsed low → counter cleared. After release, `sw_db[0]` rises only after the full 2+4 edges.
